ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl.sv | 57 +++++
 tb/tb_ram_fifo_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: pointer/flag controller for a FIFO backed by an external dual-port RAM with async read
module ram_fifo_ctrl #(
  parameter int AW = 3,
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata
);
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
  logic push_ok, pop_ok;
  assign empty = wptr_q == rptr_q;
  assign full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;
  assign push_ok = push & ~full;
  assign pop_ok = pop & ~empty;
  assign ram_we = push_ok & ~rst;
  assign ram_waddr = wptr_q[AW-1:0];
  assign ram_wdata = din;
  assign ram_raddr = rptr_q[AW-1:0];
  assign dout = dout_q;
  assign dout_valid = valid_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;
  always_comb begin
    wptr_d = rst ? '0 : wptr_q + {{AW{1'b0}}, push_ok};
    rptr_d = rst ? '0 : rptr_q + {{AW{1'b0}}, pop_ok};
    dout_d = rst ? '0 : pop_ok ? ram_rdata : dout_q;
    valid_d = ~rst & pop_ok;
    ovf_d = ~rst & push & full;
    unf_d = ~rst & pop & empty;
  end
  always_ff @(posedge clk) begin
    wptr_q <= wptr_d;
    rptr_q <= rptr_d;
    dout_q <= dout_d;
    valid_q <= valid_d;
    ovf_q <= ovf_d;
    unf_q <= unf_d;
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: randomized and directed checks of ram_fifo_ctrl against a queue-based model
module tb_ram_fifo_ctrl;
  localparam int AW = 3, DW = 4, DP = 8;
  logic clk = 0, rst = 0, push = 0, pop = 0;
  logic [DW-1:0] din = 0, dout, ram_wdata, ram_rdata;
  logic dout_valid, full, empty, overflow, underflow, ram_we;
  logic [AW:0] count;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] mem [DP];
  int q[$];
  int m_dout = 0, m_valid = 0, m_ovf = 0, m_unf = 0, wn = 0, rn = 0;
  int passed = 0, total = 0;
  bit chk_en = 0;
  ram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop), .dout(dout),
    .dout_valid(dout_valid), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
  assign ram_rdata = mem[ram_raddr];
  function automatic void check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction
  always @(negedge clk) if (chk_en) begin
    check("count", int'(count), q.size());
    check("empty", int'(empty), int'(q.size() == 0));
    check("full", int'(full), int'(q.size() == DP));
    check("dout", int'(dout), m_dout);
    check("dout_valid", int'(dout_valid), m_valid);
    check("overflow", int'(overflow), m_ovf);
    check("underflow", int'(underflow), m_unf);
  end
  task automatic cyc(input bit p, input int d, input bit po, input bit r);
    bit fm, em;
    push = p; din = DW'(d); pop = po; rst = r;
    #1;
    fm = q.size() == DP;
    em = q.size() == 0;
    if (chk_en) begin
      check("ram_we", int'(ram_we), int'(p && !r && !fm));
      if (p && !r && !fm) begin
        check("ram_waddr", int'(ram_waddr), wn % DP);
        check("ram_wdata", int'(ram_wdata), d % 16);
      end
      check("ram_raddr", int'(ram_raddr), rn % DP);
    end
    @(posedge clk);
    #1;
    if (r) begin
      q.delete(); wn = 0; rn = 0; m_dout = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
    end else begin
      m_valid = int'(po && !em);
      if (po && !em) begin m_dout = q.pop_front(); rn++; end
      if (p && !fm) begin q.push_back(d % 16); wn++; end
      m_ovf = int'(p && fm);
      m_unf = int'(po && em);
    end
    chk_en = 1;
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("lit_reset_count", int'(count), 0);
    check("lit_reset_empty", int'(empty), 1);
    for (int i = 1; i <= 8; i++) cyc(1, i, 0, 0);
    check("lit_full_count", int'(count), 8);
    check("lit_full", int'(full), 1);
    cyc(1, 9, 0, 0);
    check("lit_overflow", int'(overflow), 1);
    cyc(0, 0, 0, 0);
    check("lit_overflow_drop", int'(overflow), 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1, 0);
      check("lit_pop_dout", int'(dout), i);
      check("lit_pop_valid", int'(dout_valid), 1);
    end
    check("lit_drained_empty", int'(empty), 1);
    cyc(0, 0, 1, 0);
    check("lit_underflow", int'(underflow), 1);
    check("lit_dout_hold", int'(dout), 8);
    for (int i = 0; i < 3; i++) cyc(1, 10 + i, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, i, 1, 0);
      check("lit_steady_count", int'(count), 3);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    cyc(1, 5, 1, 0);
    check("lit_empty_pp_count", int'(count), 1);
    check("lit_empty_pp_unf", int'(underflow), 1);
    check("lit_empty_pp_valid", int'(dout_valid), 0);
    for (int i = 0; i < 7; i++) cyc(1, i + 2, 0, 0);
    cyc(1, 15, 1, 0);
    check("lit_full_pp_count", int'(count), 7);
    check("lit_full_pp_ovf", int'(overflow), 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    check("lit_pre_rst_count", int'(count), 5);
    cyc(1, 3, 0, 1);
    check("lit_rst_count", int'(count), 0);
    check("lit_rst_empty", int'(empty), 1);
    check("lit_rst_dout", int'(dout), 0);
    for (int i = 0; i < 3000; i++)
      cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
          bit'($urandom_range(0, 2) == 0 ? 1 : 0) | bit'(i % 400 > 200 && $urandom_range(0, 1) == 1),
          bit'($urandom_range(0, 199) == 0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
